hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage core.
- It produces the per-stage enable and flush controls, including the flush/EN pair that feeds the decode/execute register.
- It consumes the execute-stage outputs of that register, the decode-stage register fields, the memory-stage request status and the cache hit signals.
- A small FSM sequences load-use bubbles, data-memory waits, instruction-fetch waits and halt.

---
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard controller; optional statistics under HAZARD_STATS_EN
module hazard_ctrl #(
    parameter int NREG  = 5,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [NREG-1:0]  decode_rs,
    input  logic [NREG-1:0]  decode_rt,
    input  logic             decode_uses_rt,
    input  logic             decode_jump,
    input  logic             exe_MemRd,
    input  logic [NREG-1:0]  exe_rt,
    input  logic             mem_MemRd,
    input  logic             mem_MemWr,
    input  logic             mem_branch_taken,
    input  logic             mem_halt,
    output logic             pc_en,
    output logic             fetch_en,
    output logic             fetch_flush,
    output logic             decode_en,
    output logic             decode_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        LU_STALL = 3'd1,
        DWAIT    = 3'd2,
        IWAIT    = 3'd3,
        HALT     = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_dreq;
    logic w_lu;

    assign w_dreq = mem_MemRd | mem_MemWr;
    assign w_lu   = exe_MemRd && (exe_rt != '0) &&
                    ((exe_rt == decode_rs) || (decode_uses_rt && (exe_rt == decode_rt)));

    // State register; reset drops any partially sequenced stall
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Prioritised hazard resolution: halt, dmem wait, redirect, load-use, ifetch wait, jump
    always_comb begin
        w_next       = RUN;
        pc_en        = 1'b1;
        fetch_en     = 1'b1;
        fetch_flush  = 1'b0;
        decode_en    = 1'b1;
        decode_flush = 1'b0;
        exmem_en     = 1'b1;
        exmem_flush  = 1'b0;
        memwb_en     = 1'b1;
        memwb_flush  = 1'b0;
        halt         = 1'b0;
        if (!nRST) begin
            pc_en     = 1'b0;
            fetch_en  = 1'b0;
            decode_en = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
        end else if ((r_state == HALT) || mem_halt) begin
            // Let the halting instruction retire through writeback once, then freeze
            w_next    = HALT;
            halt      = 1'b1;
            pc_en     = 1'b0;
            fetch_en  = 1'b0;
            decode_en = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = (r_state != HALT);
        end else if (w_dreq && !dhit) begin
            w_next      = DWAIT;
            pc_en       = 1'b0;
            fetch_en    = 1'b0;
            decode_en   = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (mem_branch_taken) begin
            fetch_flush  = 1'b1;
            decode_flush = 1'b1;
            exmem_flush  = 1'b1;
        end else if (r_state == DWAIT) begin
            // Data access just completed: the whole pipe advances unmodified
            w_next = RUN;
        end else if (w_lu && (r_state == RUN)) begin
            w_next       = LU_STALL;
            pc_en        = 1'b0;
            fetch_en     = 1'b0;
            decode_flush = 1'b1;
        end else if (!ihit) begin
            w_next      = IWAIT;
            pc_en       = 1'b0;
            fetch_flush = 1'b1;
        end else if (decode_jump) begin
            fetch_flush = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_flush_evt;

    // A redirect raises decode_flush and exmem_flush together; a load-use bubble only decode_flush
    assign w_flush_evt = decode_flush | exmem_flush;

    // Saturating stall and flush event counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_en && !halt && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_flush_evt && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
